csa_wide_add_seq: RTL and testbench
===================================

CSA_WIDE_ADD_SEQ -- requirements
Module: csa_wide_add_seq

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16: chunk width added per cycle; legal values 1, 2, 4, 8, 16, 32, 64.
REQ-002 The block SHALL have parameter WORDS, default 4: number of chunks per operand, WORDS >= 1; TOTAL = DATA_WIDTH*WORDS.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand set a/b/cin valid.
REQ-007 in_ready  output  1  block can accept an operand set.
REQ-008 a  input  TOTAL  addend A.
REQ-009 b  input  TOTAL  addend B.
REQ-010 cin  input  1  carry-in for chunk 0.
REQ-011 out_valid  output  1  sum/cout valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 sum  output  TOTAL  registered result, bits [TOTAL-1:0] of a+b+cin.
REQ-014 cout  output  1  registered carry-out of the full TOTAL-bit add.
REQ-015 busy  output  1  high in RUN or DONE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-017 IDLE: in_ready=1; on a clock edge with in_valid=1, capture a, b, cin into operand registers, clear chunk index idx to 0, load carry register with cin, go to RUN.
REQ-018 RUN: each cycle, feed chunk idx of the captured A and B plus the carry register to one csa_block instance; write its sum into sum chunk idx and its cout into the carry register; increment idx.
REQ-019 RUN SHALL last exactly WORDS cycles, moving to DONE on the edge that processes chunk WORDS-1; cout takes the final carry on that edge.
REQ-020 Latency: if acceptance happens at edge T, out_valid SHALL be 1 after edge T+WORDS.
REQ-021 DONE: out_valid=1; sum and cout SHALL hold stable until an edge with out_ready=1, which returns the FSM to IDLE.
REQ-022 in_ready SHALL be 0 in RUN and DONE; in_valid is ignored there and no operand is captured.
REQ-023 There is no IDLE bypass, so minimum accept-to-accept spacing is WORDS+2 cycles.
REQ-024 Arithmetic is unsigned modulo 2^TOTAL; overflow is reported only via cout.
REQ-025 The carry chain SHALL pass only through the carry register; there is no combinational path from a, b or cin to any output.
REQ-026 sum SHALL keep its last result in IDLE; out_valid=0 in IDLE and RUN.
REQ-027 idx width SHALL be max(1, clog2(WORDS)); idx never exceeds WORDS-1.
REQ-028 A DATA_WIDTH outside the legal set, or WORDS < 1, SHALL cause an elaboration-time error rather than a silent fallback.

Reset
REQ-029 While rst=1 at a clock edge, the block SHALL go to IDLE with sum=0, cout=0, out_valid=0, busy=0, idx=0, carry=0 and operand registers cleared; in_ready=1 on the cycle after.
REQ-030 Reset in RUN or DONE SHALL abort the operation and produce no out_valid for it.
REQ-031 Reset SHALL take priority over in_valid and out_ready on the same edge.

Structure
REQ-032 A shared package csa_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and a constant function that checks legal DATA_WIDTH values.
REQ-033 The block SHALL contain exactly one sub-module: a single csa_block instance with parameter DATA_WIDTH.
REQ-034 All control logic SHALL be local, in one FSM plus the idx counter.

Verification (DATA_WIDTH=16, WORDS=4 unless stated)
REQ-035 a=64'h0000_0000_0000_0001, b=64'hFFFF_FFFF_FFFF_FFFF, cin=0 -> sum=0, cout=1, out_valid exactly 4 cycles after acceptance (carry ripples through all chunks).
REQ-036 a=64'h0123_4567_89AB_CDEF, b=64'hFEDC_BA98_7654_3210, cin=0 -> sum=64'hFFFF_FFFF_FFFF_FFFF, cout=0; with cin=1 -> sum=0, cout=1.
REQ-037 Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> sum/cout/out_valid stable, in_ready=0, no capture; out_ready=1 -> IDLE next cycle.
REQ-038 Reset asserted on the 2nd RUN cycle -> next cycle: IDLE, in_ready=1, out_valid=0, sum=0, cout=0; a later operation completes correctly.
REQ-039 Back-to-back: in_valid and out_ready held at 1 with two operand sets -> acceptances 6 cycles apart; both results match the reference a+b+cin.
REQ-040 DATA_WIDTH=8, WORDS=1: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, out_valid 1 cycle after acceptance.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared types and parameter checks for the sequential chunked wide adder.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True only for the chunk widths the datapath is built for.
  function automatic bit legal_data_width(input int w);
    case (w)
      1, 2, 4, 8, 16, 32, 64: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csa_block.sv
// One chunk of the wide add: DATA_WIDTH-bit sum with carry in and carry out.
module csa_block #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_cin,
  output logic [DATA_WIDTH-1:0] o_sum,
  output logic                  o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{DATA_WIDTH{1'b0}}, i_cin};

endmodule

// File: rtl/csa_wide_add_seq.sv
// Adds two TOTAL-bit operands one DATA_WIDTH chunk per cycle through a single
// csa_block, rippling the carry through a register between chunks.
module csa_wide_add_seq
  import csa_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int WORDS      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH*WORDS-1:0] a,
  input  logic [DATA_WIDTH*WORDS-1:0] b,
  input  logic                        cin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH*WORDS-1:0] sum,
  output logic                        cout,
  output logic                        busy
);

  localparam int TOTAL = DATA_WIDTH * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  if (!legal_data_width(DATA_WIDTH) || (WORDS < 1)) begin : g_param_error
    $error("csa_wide_add_seq: illegal DATA_WIDTH or WORDS");
  end

  state_t                  r_state;
  state_t                  w_state_next;
  logic [TOTAL-1:0]        r_a;
  logic [TOTAL-1:0]        r_b;
  logic [TOTAL-1:0]        r_sum;
  logic                    r_carry;
  logic                    r_cout;
  logic [IDX_W-1:0]        r_idx;

  logic [DATA_WIDTH-1:0]   w_a_chunk;
  logic [DATA_WIDTH-1:0]   w_b_chunk;
  logic [DATA_WIDTH-1:0]   w_chunk_sum;
  logic                    w_chunk_cout;
  logic                    w_last;

  assign w_a_chunk = r_a[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign w_b_chunk = r_b[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign w_last    = (r_idx == IDX_W'(WORDS - 1));

  csa_block #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_csa_block (
    .i_a    (w_a_chunk),
    .i_b    (w_b_chunk),
    .i_cin  (r_carry),
    .o_sum  (w_chunk_sum),
    .o_cout (w_chunk_cout)
  );

  // NOTE: every default is assigned before the case so no path leaves
  // w_state_next unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_sum[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH] <= w_chunk_sum;
          r_carry <= w_chunk_cout;
          // Index wraps to 0 after the last chunk so it never exceeds WORDS-1.
          if (w_last) begin
            r_cout <= w_chunk_cout;
            r_idx  <= '0;
          end else begin
            r_idx  <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_csa_wide_add_seq.sv
// Self-checking bench: directed and random operands against a plain a+b+cin model.
module tb_csa_wide_add_seq;

  localparam int DW = 16;
  localparam int W  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [63:0] a, b, sum;

  logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
  logic [7:0]  a1, b1, sum1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  csa_wide_add_seq #(.DATA_WIDTH(DW), .WORDS(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  csa_wide_add_seq #(.DATA_WIDTH(8), .WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: full-precision add, bit 64 is the carry-out.
  function automatic logic [64:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                          input logic c);
    return {1'b0, x} + {1'b0, y} + 65'(c);
  endfunction

  task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_, input logic tc,
                        input string tag);
    logic [64:0] exp;
    int          lat;
    exp = ref_add(ta, tb_, tc);
    lat = 0;
    while (!in_ready && lat < 20) begin step(); lat++; end
    check({tag, "/in_ready"}, 65'(in_ready), 65'(1));
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, "/busy"}, 65'(busy), 65'(1));
    lat = 0;
    while (!out_valid && lat < 50) begin step(); lat++; end
    check({tag, "/latency"}, 65'(lat), 65'(W));
    check({tag, "/sum"},  65'(sum),  65'(exp[63:0]));
    check({tag, "/cout"}, 65'(cout), 65'(exp[64]));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "/idle_ready"}, 65'(in_ready),  65'(1));
    check({tag, "/idle_valid"}, 65'(out_valid), 65'(0));
    check({tag, "/sum_kept"},   65'(sum),       65'(exp[63:0]));
  endtask

  initial begin
    logic [64:0] exp;
    logic [63:0] ra, rb;
    logic        rc;
    logic [63:0] ba [2];
    logic [63:0] bb [2];
    logic        bc [2];
    int          acc_cyc [2];
    int          n_acc, n_res, lat;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    step(); step();
    check("rst/in_ready",  65'(in_ready),  65'(1));
    check("rst/out_valid", 65'(out_valid), 65'(0));
    check("rst/busy",      65'(busy),      65'(0));
    check("rst/sum",       65'(sum),       65'(0));
    check("rst/cout",      65'(cout),      65'(0));
    rst = 1'b0;
    step();

    // Carry ripples through every chunk.
    run_op(64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "ripple");
    run_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, "comp_cin0");
    run_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, "comp_cin1");
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "all_ones");

    for (int i = 0; i < 8; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom);
      run_op(ra, rb, rc, "random");
    end

    // Backpressure in DONE with a competing operand set on the input.
    ra = 64'h1111_2222_3333_4444; rb = 64'h0F0F_F0F0_0F0F_F0F0;
    exp = ref_add(ra, rb, 1'b1);
    a = ra; b = rb; cin = 1'b1; in_valid = 1'b1;
    step();
    a = 64'hDEAD_BEEF_DEAD_BEEF; b = 64'h1234_5678_9ABC_DEF0; cin = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin step(); lat++; end
    check("bp/latency", 65'(lat), 65'(W));
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp/out_valid", 65'(out_valid), 65'(1));
      check("bp/in_ready",  65'(in_ready),  65'(0));
      check("bp/result",    {cout, sum},    exp);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp/released",  65'(in_ready),  65'(1));
    check("bp/no_valid",  65'(out_valid), 65'(0));

    // Reset on the second RUN cycle aborts the operation.
    a = 64'hAAAA_5555_AAAA_5555; b = 64'h5555_AAAA_5555_AAAA; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort/in_ready",  65'(in_ready),  65'(1));
    check("abort/out_valid", 65'(out_valid), 65'(0));
    check("abort/sum",       65'(sum),       65'(0));
    check("abort/cout",      65'(cout),      65'(0));
    check("abort/busy",      65'(busy),      65'(0));
    for (int i = 0; i < W + 2; i++) begin
      step();
      check("abort/quiet", 65'(out_valid), 65'(0));
    end
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0, "after_abort");

    // Back-to-back with in_valid and out_ready held high.
    ba[0] = {$urandom, $urandom}; bb[0] = {$urandom, $urandom}; bc[0] = 1'b1;
    ba[1] = {$urandom, $urandom}; bb[1] = {$urandom, $urandom}; bc[1] = 1'b0;
    a = ba[0]; b = bb[0]; cin = bc[0];
    in_valid = 1'b1; out_ready = 1'b1;
    n_acc = 0; n_res = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    for (int c = 0; c < 40 && n_res < 2; c++) begin
      if (out_valid) begin
        exp = ref_add(ba[n_res], bb[n_res], bc[n_res]);
        check("b2b/result", {cout, sum}, exp);
        n_res++;
      end
      if (in_ready && in_valid && n_acc < 2) begin
        acc_cyc[n_acc] = c;
        n_acc++;
      end
      step();
      if (n_acc == 1) begin a = ba[1]; b = bb[1]; cin = bc[1]; end
      if (n_acc == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b/results_seen", 65'(n_res), 65'(2));
    check("b2b/spacing", 65'(acc_cyc[1] - acc_cyc[0]), 65'(W + 2));
    step();

    // Single-chunk instance: 8-bit, one word.
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin a1 = 8'hFF; b1 = 8'h01; cin1 = 1'b0; end
      else begin a1 = 8'($urandom); b1 = 8'($urandom); cin1 = 1'($urandom); end
      exp = 65'({1'b0, a1} + {1'b0, b1} + 9'(cin1));
      check("w1/in_ready", 65'(in_ready1), 65'(1));
      in_valid1 = 1'b1;
      step();
      in_valid1 = 1'b0;
      lat = 0;
      while (!out_valid1 && lat < 20) begin step(); lat++; end
      check("w1/latency", 65'(lat), 65'(1));
      check("w1/result", 65'({cout1, sum1}), exp);
      out_ready1 = 1'b1;
      step();
      out_ready1 = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
